val2_shift_sequencer: RTL



---
 rtl/val2_pkg.sv | 38 +++
 rtl/val2_step_unit.sv | 32 +++
 rtl/val2_shift_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/val2_pkg.sv
// Shared definitions for the Val2 shift sequencer: shift types, FSM state
// encoding and bit positions of the 12-bit shifter operand field.
package val2_pkg;

  localparam int DATA_W = 32;
  localparam int SO_W   = 12;
  localparam int CNT_W  = 6;   // holds 0..32

  // Shift type encoding as carried in shifter operand bits [6:5]
  typedef logic [1:0] sh_type_t;
  localparam sh_type_t SH_LSL = 2'b00;
  localparam sh_type_t SH_LSR = 2'b01;
  localparam sh_type_t SH_ASR = 2'b10;
  localparam sh_type_t SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Register-shift form
  localparam int SO_AMT_MSB  = 11;
  localparam int SO_AMT_LSB  = 7;
  localparam int SO_TYPE_MSB = 6;
  localparam int SO_TYPE_LSB = 5;
  // Rotated-immediate form
  localparam int SO_ROT_MSB  = 11;
  localparam int SO_ROT_LSB  = 8;
  localparam int SO_IMM_MSB  = 7;
  localparam int SO_IMM_LSB  = 0;

  // Rotate field counts in units of two bit positions
  function automatic logic [CNT_W-1:0] rot_count(input logic [3:0] rot);
    return {1'b0, rot, 1'b0};
  endfunction

endpackage

// File: rtl/val2_step_unit.sv
// Combinational single step of the Val2 shifter: shifts a 32-bit value by
// k positions (0..STEP) using LSL, LSR, ASR (sign fill) or ROR (wrap).
module val2_step_unit
  import val2_pkg::*;
#(
  parameter  int STEP = 4,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [KW-1:0]     k,
  input  sh_type_t          sh_type,
  output logic [DATA_W-1:0] data_out
);

  logic        [CNT_W-1:0]  amt;
  logic signed [DATA_W-1:0] sdata;

  // Apply one shift step of the requested type
  always_comb begin
    amt      = CNT_W'(k);
    sdata    = $signed(data_in);
    data_out = data_in;
    case (sh_type)
      SH_LSL: data_out = data_in << amt;
      SH_LSR: data_out = data_in >> amt;
      SH_ASR: data_out = $unsigned(sdata >>> amt);
      SH_ROR: data_out = (data_in >> amt) | (data_in << (6'd32 - amt));
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle, handshaked Val2 operand generator. Accepts one request,
// iterates the shift/rotate at most STEP bits per clock, then holds the
// result under valid/ready. busy marks SHIFT so the EXE stage can stall.
// Optional build macro VAL2_SEQ_STATS_EN adds saturating stat_ops /
// stat_busy counters.
module val2_shift_sequencer
  import val2_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] operand_in,
  input  logic [SO_W-1:0]   shift_operand,
  input  logic              is_immediate,
  input  logic              sign_extend,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand_out,
  output logic              busy
`ifdef VAL2_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_busy
`endif
);

  localparam int              KW     = $clog2(STEP + 1);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  sh_type_t          type_q, type_d;

  logic              accept;
  logic [DATA_W-1:0] load_work;
  logic [CNT_W-1:0]  load_rem;
  sh_type_t          load_type;
  logic [CNT_W-1:0]  step_amt;
  logic [KW-1:0]     step_k;
  logic [CNT_W-1:0]  rem_after;
  logic [DATA_W-1:0] step_out;

  // Handshake: a retiring result and a new request may share one edge
  always_comb begin
    in_ready = ~flush & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    accept   = in_valid & in_ready;
  end

  // Decode the request into working value, shift count and type
  always_comb begin
    load_work = operand_in;
    load_rem  = {1'b0, shift_operand[SO_AMT_MSB:SO_AMT_LSB]};
    load_type = shift_operand[SO_TYPE_MSB:SO_TYPE_LSB];
    if (sign_extend) begin
      load_work = {{(DATA_W - SO_W){shift_operand[SO_W-1]}}, shift_operand};
      load_rem  = '0;
      load_type = SH_LSL;
    end else if (is_immediate) begin
      load_work = {{(DATA_W - 8){1'b0}}, shift_operand[SO_IMM_MSB:SO_IMM_LSB]};
      load_rem  = rot_count(shift_operand[SO_ROT_MSB:SO_ROT_LSB]);
      load_type = SH_ROR;
    end
  end

  // Step size this cycle is min(STEP, remaining)
  always_comb begin
    step_amt  = (rem_q > STEP_C) ? STEP_C : rem_q;
    step_k    = KW'(step_amt);
    rem_after = rem_q - step_amt;
  end

  val2_step_unit #(
    .STEP (STEP)
  ) u_step (
    .data_in  (work_q),
    .k        (step_k),
    .sh_type  (type_q),
    .data_out (step_out)
  );

  // FSM next state; flush aborts from any state and blocks acceptance
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) state_d = (load_rem != '0) ? SHIFT : DONE;
        end
        SHIFT: begin
          if (rem_after == '0) state_d = DONE;
        end
        DONE: begin
          if (accept)         state_d = (load_rem != '0) ? SHIFT : DONE;
          else if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Working register update: load on accept, step while shifting
  always_comb begin
    work_d = work_q;
    rem_d  = rem_q;
    type_d = type_q;
    if (flush) begin
      rem_d = '0;
    end else if (accept) begin
      work_d = load_work;
      rem_d  = load_rem;
      type_d = load_type;
    end else if (state_q == SHIFT) begin
      work_d = step_out;
      rem_d  = rem_after;
    end
  end

  // FSM outputs decoded from the registered state
  always_comb begin
    out_valid   = (state_q == DONE);
    busy        = (state_q == SHIFT);
    operand_out = work_q;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      type_q  <= SH_LSL;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
    end
  end

`ifdef VAL2_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_busy_q, stat_busy_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Retired results (flush discards, so it does not count) and SHIFT cycles
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_busy_d = stat_busy_q;
    if (out_valid & out_ready & ~flush) stat_ops_d  = sat_inc(stat_ops_q);
    if (busy)                           stat_busy_d = sat_inc(stat_busy_q);
    stat_ops  = stat_ops_q;
    stat_busy = stat_busy_q;
  end

  // Counters clear on reset only
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_busy_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_busy_q <= stat_busy_d;
    end
  end
`endif

endmodule
